// File: rtl/lsu_pkg.sv
// Shared types, exception codes and opcode helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [3:0] {
        OpLdB  = 4'b0000,
        OpLdH  = 4'b0001,
        OpLdW  = 4'b0010,
        OpLdD  = 4'b0011,
        OpStB  = 4'b0100,
        OpStH  = 4'b0101,
        OpStW  = 4'b0110,
        OpStD  = 4'b0111,
        OpLdBU = 4'b1000,
        OpLdHU = 4'b1001,
        OpLdWU = 4'b1010
    } lsu_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StRsp,
        StDrain,
        StDone
    } lsu_state_e;

    localparam int unsigned EXC_ALE    = 0;
    localparam int unsigned EXC_BUSERR = 1;

    // log2 of the access size in bytes; the low two opcode bits encode it directly
    function automatic logic [1:0] lsu_size(input logic [3:0] op);
        return op[1:0];
    endfunction

    function automatic logic lsu_is_store(input logic [3:0] op);
        return op[3:2] == 2'b01;
    endfunction

    function automatic logic lsu_op_supported(input logic [3:0] op, input logic wide);
        case (op)
            OpLdB, OpLdH, OpLdW, OpStB, OpStH, OpStW, OpLdBU, OpLdHU: return 1'b1;
            OpLdD, OpStD, OpLdWU:                                     return wide;
            default:                                                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory request/response bus between the load/store unit and memory.
interface lsu_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    localparam int unsigned NB = DATA_WIDTH / 8;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [NB-1:0]         mem_wmask;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_err;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_gnt, mem_rvalid, mem_rdata, mem_err
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_gnt, mem_rvalid, mem_rdata, mem_err
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane placement for stores and extraction/extension for loads.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned NB    = DATA_WIDTH / 8,
    localparam int unsigned OFF_W = $clog2(NB)
) (
    input  logic [3:0]            op,
    input  logic [OFF_W-1:0]      off,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [NB-1:0]         wmask,
    output logic [DATA_WIDTH-1:0] wdata_sh,
    output logic [DATA_WIDTH-1:0] rdata_ext,
    output logic                  misaligned
);

    logic [1:0]            size;
    logic [DATA_WIDTH-1:0] shifted_w;
    logic [DATA_WIDTH-1:0] shifted_r;
    logic [DATA_WIDTH-1:0] keep;
    logic [DATA_WIDTH-1:0] top;
    logic                  sign;

    always_comb begin
        size       = lsu_size(op);
        misaligned = |(off & ~({OFF_W{1'b1}} << size));
        wmask      = ~({NB{1'b1}} << (4'd1 << size)) << off;

        shifted_w = wdata << {off, 3'b000};
        wdata_sh  = '0;
        for (int i = 0; i < int'(NB); i++) begin
            wdata_sh[i*8 +: 8] = wmask[i] ? shifted_w[i*8 +: 8] : 8'h00;
        end

        // keep covers the access width; its top bit is the sign bit for signed loads
        shifted_r = rdata >> {off, 3'b000};
        keep      = ~({DATA_WIDTH{1'b1}} << (7'd8 << size));
        top       = keep & ~(keep >> 1);
        sign      = ~op[3] & ~op[2] & (|(shifted_r & top));
        rdata_ext = (shifted_r & keep) | ({DATA_WIDTH{sign}} & ~keep);
    end

endmodule

// File: rtl/lsu_unit.sv
// Handshaked multi-cycle load/store unit: one operation at a time, registered outputs,
// ALE/bus-error reporting and flush with response draining.
module lsu_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_lsu_op,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_wdata,
    lsu_if.master                 mem,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_rdata,
    output logic [1:0]            out_except
);

    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam logic        Wide  = (DATA_WIDTH == 64);
    localparam logic [1:0]  AleCode    = 2'(1 << EXC_ALE);
    localparam logic [1:0]  BusErrCode = 2'(1 << EXC_BUSERR);

    lsu_state_e            state_q, state_d;
    logic [3:0]            op_q, op_d;
    logic [OFF_W-1:0]      off_q, off_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [NB-1:0]         mem_wmask_q, mem_wmask_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_rdata_q, out_rdata_d;
    logic [1:0]            out_except_q, out_except_d;

    logic                  idle;
    logic [OFF_W-1:0]      in_off;
    logic [3:0]            al_op;
    logic [OFF_W-1:0]      al_off;
    logic [NB-1:0]         al_wmask;
    logic [DATA_WIDTH-1:0] al_wdata;
    logic [DATA_WIDTH-1:0] al_rdata;
    logic                  al_misaligned;

    assign idle   = (state_q == StIdle);
    assign in_off = in_addr[OFF_W-1:0];
    // Store placement happens at accept time, load extraction once the op is latched
    assign al_op  = idle ? in_lsu_op : op_q;
    assign al_off = idle ? in_off : off_q;

    lsu_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_align (
        .op        (al_op),
        .off       (al_off),
        .wdata     (in_wdata),
        .rdata     (mem.mem_rdata),
        .wmask     (al_wmask),
        .wdata_sh  (al_wdata),
        .rdata_ext (al_rdata),
        .misaligned(al_misaligned)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        off_d        = off_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wmask_d  = mem_wmask_q;
        out_valid_d  = out_valid_q;
        out_rdata_d  = out_rdata_q;
        out_except_d = out_except_q;

        case (state_q)
            StIdle: begin
                if (in_valid && !flush) begin
                    op_d  = in_lsu_op;
                    off_d = in_off;
                    if (!lsu_op_supported(in_lsu_op, Wide)) begin
                        state_d      = StDone;
                        out_valid_d  = 1'b1;
                        out_rdata_d  = '0;
                        out_except_d = '0;
                    end else if (al_misaligned) begin
                        state_d      = StDone;
                        out_valid_d  = 1'b1;
                        out_rdata_d  = '0;
                        out_except_d = AleCode;
                    end else begin
                        state_d     = StReq;
                        mem_req_d   = 1'b1;
                        mem_we_d    = lsu_is_store(in_lsu_op);
                        mem_addr_d  = {in_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                        mem_wmask_d = al_wmask;
                        mem_wdata_d = lsu_is_store(in_lsu_op) ? al_wdata : '0;
                    end
                end
            end
            StReq: begin
                if (mem.mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = flush ? StDrain : StRsp;
                end else if (flush) begin
                    mem_req_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            StRsp: begin
                if (mem.mem_rvalid) begin
                    if (flush) begin
                        state_d = StIdle;
                    end else begin
                        state_d      = StDone;
                        out_valid_d  = 1'b1;
                        out_rdata_d  = (mem.mem_err || lsu_is_store(op_q)) ? '0 : al_rdata;
                        out_except_d = mem.mem_err ? BusErrCode : 2'b00;
                    end
                end else if (flush) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (mem.mem_rvalid) begin
                    state_d = StIdle;
                end
            end
            StDone: begin
                if (flush || out_ready) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = StIdle;
                mem_req_d   = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            op_q         <= '0;
            off_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wmask_q  <= '0;
            out_valid_q  <= 1'b0;
            out_rdata_q  <= '0;
            out_except_q <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            off_q        <= off_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wmask_q  <= mem_wmask_d;
            out_valid_q  <= out_valid_d;
            out_rdata_q  <= out_rdata_d;
            out_except_q <= out_except_d;
        end
    end

    assign in_ready      = idle;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_wmask = mem_wmask_q;
    assign out_valid     = out_valid_q;
    assign out_rdata     = out_rdata_q;
    assign out_except    = out_except_q;

endmodule

// File: tb/tb_lsu_unit.sv
// Directed bench driving a 32-bit and a 64-bit lsu_unit in lockstep from shared stimulus.
module tb_lsu_unit;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        gnt;
    logic        rvalid;
    logic        err;

    logic        in_ready32, in_ready64;
    logic        out_valid32, out_valid64;
    logic [31:0] out_rdata32;
    logic [63:0] out_rdata64;
    logic [1:0]  out_except32, out_except64;

    int checks;
    int errors;

    lsu_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) m32 ();
    lsu_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) m64 ();

    assign m32.mem_gnt    = gnt;
    assign m32.mem_rvalid = rvalid;
    assign m32.mem_rdata  = rdata[31:0];
    assign m32.mem_err    = err;
    assign m64.mem_gnt    = gnt;
    assign m64.mem_rvalid = rvalid;
    assign m64.mem_rdata  = rdata;
    assign m64.mem_err    = err;

    lsu_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut32 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready32),
        .in_lsu_op (op),
        .in_addr   (addr),
        .in_wdata  (wdata[31:0]),
        .mem       (m32),
        .out_valid (out_valid32),
        .out_ready (out_ready),
        .out_rdata (out_rdata32),
        .out_except(out_except32)
    );

    lsu_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut64 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready64),
        .in_lsu_op (op),
        .in_addr   (addr),
        .in_wdata  (wdata),
        .mem       (m64),
        .out_valid (out_valid64),
        .out_ready (out_ready),
        .out_rdata (out_rdata64),
        .out_except(out_except64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single cycle; returns in the cycle after the accept edge
    task automatic accept(input logic [3:0] o, input logic [31:0] a, input logic [63:0] w);
        op       = o;
        addr     = a;
        wdata    = w;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Immediate grant then a response one cycle later; returns in the out_valid cycle
    task automatic respond(input logic [63:0] d, input logic e);
        gnt = 1'b1;
        tick();
        gnt    = 1'b0;
        rvalid = 1'b1;
        rdata  = d;
        err    = e;
        tick();
        rvalid = 1'b0;
        err    = 1'b0;
    endtask

    task automatic retire();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 4'h0;
        addr      = '0;
        wdata     = '0;
        rdata     = '0;
        gnt       = 1'b0;
        rvalid    = 1'b0;
        err       = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready32", in_ready32, 1);
        chk("rst_in_ready64", in_ready64, 1);
        chk("rst_mem_req", {m32.mem_req, m64.mem_req}, 0);
        chk("rst_mem_we", {m32.mem_we, m64.mem_we}, 0);
        chk("rst_mem_addr", m32.mem_addr, 0);
        chk("rst_mem_wdata", m64.mem_wdata, 0);
        chk("rst_mem_wmask", {m32.mem_wmask, m64.mem_wmask}, 0);
        chk("rst_out_valid", {out_valid32, out_valid64}, 0);
        chk("rst_out_rdata", out_rdata64, 0);
        chk("rst_out_except", {out_except32, out_except64}, 0);

        // ST.H at 0x1002
        accept(4'b0101, 32'h1002, 64'hABCD1234);
        chk("sth_in_ready", in_ready32, 0);
        chk("sth_req32", m32.mem_req, 1);
        chk("sth_we32", m32.mem_we, 1);
        chk("sth_addr32", m32.mem_addr, 32'h1000);
        chk("sth_mask32", m32.mem_wmask, 4'b1100);
        chk("sth_wdata32", m32.mem_wdata, 32'h12340000);
        chk("sth_addr64", m64.mem_addr, 32'h1000);
        chk("sth_mask64", m64.mem_wmask, 8'b0000_1100);
        chk("sth_wdata64", m64.mem_wdata, 64'h12340000);
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        chk("sth_req_drop", {m32.mem_req, m64.mem_req}, 0);
        chk("sth_no_early_valid", {out_valid32, out_valid64}, 0);
        rvalid = 1'b1;
        rdata  = '0;
        tick();
        rvalid = 1'b0;
        chk("sth_out_valid", {out_valid32, out_valid64}, 2'b11);
        chk("sth_except", {out_except32, out_except64}, 0);
        chk("sth_rdata", out_rdata32, 0);
        retire();
        chk("sth_back_idle", {in_ready32, in_ready64, out_valid32}, 3'b110);

        // LD.B / LD.BU at 0x1003
        accept(4'b0000, 32'h1003, '0);
        chk("ldb_we", {m32.mem_we, m64.mem_we}, 0);
        chk("ldb_addr32", m32.mem_addr, 32'h1000);
        respond(64'h80FF0000, 1'b0);
        chk("ldb_rdata32", out_rdata32, 32'hFFFFFF80);
        chk("ldb_rdata64", out_rdata64, 64'hFFFFFFFF_FFFFFF80);
        retire();
        accept(4'b1000, 32'h1003, '0);
        respond(64'h80FF0000, 1'b0);
        chk("ldbu_rdata32", out_rdata32, 32'h80);
        chk("ldbu_rdata64", out_rdata64, 64'h80);
        retire();

        // Misaligned ST.W: completes next cycle with ALE, no request
        accept(4'b0110, 32'h1001, 64'h55);
        chk("ale_valid", {out_valid32, out_valid64}, 2'b11);
        chk("ale_except32", out_except32, 2'b01);
        chk("ale_except64", out_except64, 2'b01);
        chk("ale_no_req", {m32.mem_req, m64.mem_req}, 0);
        retire();
        chk("ale_no_req_after", {m32.mem_req, m64.mem_req}, 0);

        // Unsupported opcode: no access, zero result
        accept(4'b1111, 32'h1000, '0);
        chk("unsup_valid", {out_valid32, out_valid64}, 2'b11);
        chk("unsup_except", {out_except32, out_except64}, 0);
        chk("unsup_no_req", {m32.mem_req, m64.mem_req}, 0);
        retire();

        // LD.W at 0x2004: sign-extended on 64-bit, low word on 32-bit
        accept(4'b0010, 32'h2004, '0);
        chk("ldw_addr64", m64.mem_addr, 32'h2000);
        chk("ldw_addr32", m32.mem_addr, 32'h2004);
        chk("ldw_mask64", m64.mem_wmask, 8'hF0);
        respond(64'h80000001_00000000, 1'b0);
        chk("ldw_rdata64", out_rdata64, 64'hFFFFFFFF_80000001);
        chk("ldw_rdata32", out_rdata32, 32'h0);
        retire();

        // LD.WU: legal on 64-bit, unsupported on 32-bit
        accept(4'b1010, 32'h2004, '0);
        chk("ldwu_unsup32", {out_valid32, out_except32, m32.mem_req}, 4'b1000);
        chk("ldwu_req64", m64.mem_req, 1);
        out_ready = 1'b1;
        gnt       = 1'b1;
        tick();
        out_ready = 1'b0;
        gnt       = 1'b0;
        chk("ldwu_idle32", in_ready32, 1);
        rvalid = 1'b1;
        rdata  = 64'h80000001_00000000;
        tick();
        rvalid = 1'b0;
        chk("ldwu_rdata64", out_rdata64, 64'h00000000_80000001);
        chk("ldwu_quiet32", out_valid32, 0);
        retire();

        // Flush in RSP, response two cycles later is drained
        accept(4'b0010, 32'h3000, '0);
        gnt = 1'b1;
        tick();
        gnt   = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("drain_busy", {in_ready32, in_ready64, out_valid32, out_valid64}, 0);
        tick();
        chk("drain_wait", {in_ready32, in_ready64}, 0);
        rvalid = 1'b1;
        rdata  = 64'hDEADBEEF_DEADBEEF;
        tick();
        rvalid = 1'b0;
        chk("drain_done", {in_ready32, in_ready64, out_valid32, out_valid64}, 4'b1100);
        accept(4'b0010, 32'h3000, '0);
        respond(64'h00000000_87654321, 1'b0);
        chk("post_drain32", out_rdata32, 32'h87654321);
        chk("post_drain64", out_rdata64, 64'hFFFFFFFF_87654321);
        retire();

        // Flush in REQ without grant, and flush coinciding with accept
        accept(4'b0010, 32'h1000, '0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("req_flush", {in_ready32, in_ready64, m32.mem_req, m64.mem_req}, 4'b1100);
        op       = 4'b0010;
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("accept_flush", {in_ready32, m32.mem_req, out_valid32}, 3'b100);

        // Reset while waiting in REQ
        accept(4'b0010, 32'h1000, '0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_midop", {in_ready32, in_ready64, m32.mem_req, m64.mem_req}, 4'b1100);

        // Bus error held under back-pressure
        accept(4'b0001, 32'h1002, '0);
        respond(64'h00000000_FFFF1111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("err_hold_valid", {out_valid32, out_valid64}, 2'b11);
            chk("err_hold_except", {out_except32, out_except64}, 4'b1010);
            chk("err_hold_rdata", {out_rdata32, out_rdata64[31:0]}, 0);
            tick();
        end
        out_ready = 1'b1;
        chk("err_ready_cycle", {out_valid32, out_valid64}, 2'b11);
        tick();
        out_ready = 1'b0;
        chk("err_retired", {out_valid32, out_valid64, in_ready32, in_ready64}, 4'b0011);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_unit.md
# lsu_unit

Parametrised load/store unit that replaces the combinational memory-access stage with a handshaked, multi-cycle data-memory client. It sits between the execute and write-back stages and has four jobs:
- Accept one memory operation at a time from execute.
- Build byte-lane masks and lane-shifted write data for any power-of-two data width.
- Issue a valid/grant request to data memory and wait for the response.
- Return sign- or zero-extended load data, or an exception code, to write-back under valid/ready.

Unlike the previous stage, it supports variable memory latency and back-pressure. It raises misaligned-address (ALE) and bus-error exceptions, and it handles pipeline flush mid-transaction.

## Interface
- `DATA_WIDTH`, default 32. Data bus width; must be 32 or 64.
- `ADDR_WIDTH`, default 32. Byte-address width.
- `NB`, derived, equals `DATA_WIDTH/8`. Number of byte lanes.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous active-high reset.
- `flush`  in  1  kill the in-flight operation.
- `in_valid`  in  1  execute presents an operation.
- `in_ready`  out  1  unit can accept an operation.
- `in_lsu_op`  in  4  operation code; bit2=1 means store (see Operation).
- `in_addr`  in  `ADDR_WIDTH`  byte address.
- `in_wdata`  in  `DATA_WIDTH`  store data, right-aligned.
- `mem_req`  out  1  memory request valid.
- `mem_we`  out  1  request is a write.
- `mem_addr`  out  `ADDR_WIDTH`  `NB`-aligned address.
- `mem_wdata`  out  `DATA_WIDTH`  lane-shifted write data.
- `mem_wmask`  out  `NB`  byte enables.
- `mem_gnt`  in  1  request accepted.
- `mem_rvalid`  in  1  response or write acknowledge.
- `mem_rdata`  in  `DATA_WIDTH`  read data.
- `mem_err`  in  1  bus error; qualified by `mem_rvalid`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  write-back accepts the result.
- `out_rdata`  out  `DATA_WIDTH`  extended load data; 0 for stores.
- `out_except`  out  2  bit0 = ALE, bit1 = BUSERR.

## Operation
Operation codes (`in_lsu_op`):
- Loads: 0000 LD.B, 0001 LD.H, 0010 LD.W, 0011 LD.D, 1000 LD.BU, 1001 LD.HU, 1010 LD.WU.
- Stores: 0100 ST.B, 0101 ST.H, 0110 ST.W, 0111 ST.D.
- LD.D, LD.WU and ST.D are legal only when `DATA_WIDTH` is 64.
- Any other code is unsupported. It completes with no memory access and with `out_rdata` = 0 and `out_except` = 0.

Access size and alignment:
- Access size is 1, 2, 4 or 8 bytes.
- `off` = `in_addr[log2(NB)-1:0]`.
- The access is misaligned when `off` is not a multiple of the size. A misaligned access issues no request and completes with ALE.

Store lane placement:
- `mem_wmask` = size-wide ones shifted left by `off`.
- `mem_wdata` = `in_wdata` shifted left by `off*8`. Lanes whose mask bit is 0 are driven to 0.

Load lane extraction:
- Shift `mem_rdata` right by `off*8`.
- Keep `size*8` bits.
- Sign-extend for LD.B, LD.H and LD.W when `DATA_WIDTH` is 64; zero-extend for the U variants.

Error and write responses:
- A response with `mem_err`=1 gives `out_except`=BUSERR and `out_rdata`=0.
- Stores also wait for `mem_rvalid`, which acts as the write acknowledge.

FSM states: IDLE, REQ, RSP, DRAIN, DONE.
- IDLE: `in_ready`=1. On accept, latch the operation. Go to DONE if the access is misaligned or unsupported, otherwise to REQ.
- REQ: `mem_req`=1, with address, data and mask held stable until `mem_gnt`. On `mem_gnt`, go to RSP.
- RSP: wait for `mem_rvalid`; latch data and error; go to DONE. A `mem_rvalid` in the same cycle as `mem_gnt` is not allowed; memory responds at least one cycle after the grant.
- DONE: `out_valid`=1 and outputs held. On `out_ready`, go to IDLE.
- DRAIN: wait for `mem_rvalid`, discard the response, go to IDLE.

Flush handling:
- In IDLE or DONE: go to IDLE.
- In REQ with no `mem_gnt` that cycle: go to IDLE. With `mem_gnt` that cycle: go to DRAIN.
- In RSP: go to IDLE if `mem_rvalid` that cycle, else go to DRAIN.
- In DRAIN: no effect.
- A flush in the same cycle as an accept in IDLE wins; the operation is not latched.

## Timing
- All outputs are registered except `in_ready`, which is decoded from the state.
- Reset values: state IDLE, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wmask`=0, `out_valid`=0, `out_rdata`=0, `out_except`=0.
- A reset in any state returns to IDLE on the next edge, and an outstanding response is ignored. Memory is reset together with the unit.
- Minimum latency with immediate grant and a one-cycle response: accept in cycle 0, `mem_req` in cycle 1, `mem_rvalid` in cycle 2, `out_valid` in cycle 3.
- ALE path: accept in cycle 0, `out_valid` in cycle 1, and `mem_req` is never asserted.
- Throughput is one operation per 4 cycles at best. There is no overlap between operations.
- `out_valid` and `out_rdata` stay stable while `out_ready`=0.

## Structure
- Package `lsu_pkg` holds:
  - `lsu_op_e` enum with the codes above;
  - `lsu_state_e` enum;
  - constants `EXC_ALE`=0 and `EXC_BUSERR`=1;
  - function `lsu_size(op)`, returning log2 of the access size.
- One combinational sub-module, `lsu_align`, parametrised on `DATA_WIDTH`. Its inputs are op, `off`, `wdata` and `rdata`; its outputs are `wmask`, the shifted `wdata`, extended `rdata` and `misaligned`.
- `lsu_unit` holds the FSM and the output registers.

## Test plan
- `DATA_WIDTH`=32, ST.H at 0x1002 with data 0xABCD1234 → `mem_we`=1, `mem_addr`=0x1000, `mem_wmask`=4'b1100, `mem_wdata`=0x12340000. `out_valid` follows the acknowledge with `out_except`=0.
- LD.B at 0x1003 with `mem_rdata`=0x80FF0000 → `out_rdata`=0xFFFFFF80. The same access as LD.BU → 0x00000080.
- ST.W at 0x1001 → no `mem_req`, `out_valid` in cycle 1, `out_except`=2'b01.
- `DATA_WIDTH`=64, LD.W at 0x2004 with `mem_rdata`=0x8000_0001_0000_0000 → 0xFFFFFFFF80000001. LD.WU → 0x0000000080000001.
- Flush in RSP, response 2 cycles later → unit goes to DRAIN. No `out_valid`; the next `in_ready` comes after the response. The result of a following load is uncorrupted.
- Response with `mem_err` and `out_ready` held low for 5 cycles → `out_valid` held with `out_except`=2'b10 and `out_rdata`=0. Completion happens on the cycle `out_ready` rises.
